// File: rtl/popcount_accum.sv
// Streaming popcount accumulator: counts ones (or XNOR matches against weights) per beat
// over a 3-stage pipeline and emits one saturating total per in_last-delimited frame.
module popcount_accum #(
    parameter  int IN_W  = 64,
    parameter  int ACC_W = 16,
    localparam int CNT_W = $clog2(IN_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [IN_W-1:0]   in_wgt,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);
    localparam int NG = IN_W / 8;

    function automatic logic [3:0] pop8(input logic [7:0] b);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, b[i]};
        end
        return c;
    endfunction

    logic                  w_stall;
    logic                  w_accept;
    logic [IN_W-1:0]       w_bits;
    logic [NG-1:0][3:0]    w_grp;
    logic [CNT_W-1:0]      w_s2_sum;
    logic [ACC_W:0]        w_sum;
    logic                  w_sat;
    logic [ACC_W-1:0]      w_acc_n;
    logic                  w_ovf_n;

    logic                  r_s1_valid;
    logic                  r_s1_last;
    logic [NG-1:0][3:0]    r_s1_cnt;
    logic                  r_s2_valid;
    logic                  r_s2_last;
    logic [CNT_W-1:0]      r_s2_cnt;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_ovf_acc;
    logic                  r_out_valid;
    logic [ACC_W-1:0]      r_out_data;
    logic                  r_out_ovf;

    // A held total freezes the whole pipeline so nothing downstream is overwritten.
    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_accept = in_valid & in_ready;
    assign w_bits   = mode ? ~(in_data ^ in_wgt) : in_data;

    always_comb begin
        w_grp = '0;
        for (int g = 0; g < NG; g++) begin
            w_grp[g] = pop8(w_bits[g*8 +: 8]);
        end
    end

    always_comb begin
        w_s2_sum = '0;
        for (int g = 0; g < NG; g++) begin
            w_s2_sum = w_s2_sum + CNT_W'(r_s1_cnt[g]);
        end
    end

    // One extra bit on the add exposes the carry used as the saturation flag.
    assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(r_s2_cnt);
    assign w_sat   = w_sum[ACC_W];
    assign w_acc_n = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_ovf_n = r_ovf_acc | w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_cnt   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_cnt   <= '0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_cnt   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_cnt   <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            r_s1_last  <= in_last;
            r_s1_cnt   <= w_grp;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_cnt   <= w_s2_sum;
        end
    end

    // A last beat hands its total to the output and restarts the frame at zero on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clr) begin
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s2_valid & r_s2_last;
            if (r_s2_valid) begin
                if (r_s2_last) begin
                    r_out_data <= w_acc_n;
                    r_out_ovf  <= w_ovf_n;
                    r_acc      <= '0;
                    r_ovf_acc  <= 1'b0;
                end else begin
                    r_acc      <= w_acc_n;
                    r_ovf_acc  <= w_ovf_n;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_popcount_accum.sv
// Scoreboard bench for popcount_accum: a 16-bit and an 8-bit accumulator instance share
// the same stimulus; hand-computed frame totals are queued and checked by a monitor.
module tb_popcount_accum;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, clr, mode, in_valid, in_last, out_ready;
    logic [63:0] in_data, in_wgt;
    logic        in_ready16, in_ready8, out_valid16, out_valid8, out_ovf16, out_ovf8;
    logic [15:0] out_data16;
    logic [7:0]  out_data8;

    int expQ[$];
    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    popcount_accum #(.IN_W(64), .ACC_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data), .in_wgt(in_wgt),
        .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_ovf(out_ovf16)
    );

    popcount_accum #(.IN_W(64), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data), .in_wgt(in_wgt),
        .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_ovf(out_ovf8)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nChecks++;
        if (actual == expected) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Frame totals are hand-computed; each width saturates at its own maximum.
    always @(negedge clk) begin
        int t;
        if (rst_n && out_valid16 && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_total", longint'(out_data16), -1);
            end else begin
                t = expQ.pop_front();
                checkOutput("total_acc16", longint'(out_data16), (t > 65535) ? 65535 : t);
                checkOutput("ovf_acc16", longint'(out_ovf16), longint'(t > 65535));
                checkOutput("valid_acc8", longint'(out_valid8), 1);
                checkOutput("total_acc8", longint'(out_data8), (t > 255) ? 255 : t);
                checkOutput("ovf_acc8", longint'(out_ovf8), longint'(t > 255));
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] data, input logic [63:0] wgt, input logic m,
                                 input logic last, input logic c, input int total);
        int waited = 0;
        bit accepted = 1'b0;
        in_data  = data;
        in_wgt   = wgt;
        mode     = m;
        in_last  = last;
        clr      = c;
        in_valid = 1'b1;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (in_ready16) accepted = 1'b1;
            else waited++;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", waited, 0);
        end else begin
            @(posedge clk);
            if (last && !c) expQ.push_back(total);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || out_valid16) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_remaining", longint'(expQ.size()), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_wgt = '0; out_ready = 1'b1;
        #2;
        checkOutput("reset_out_valid", longint'(out_valid16), 0);
        checkOutput("reset_out_data", longint'(out_data16), 0);
        checkOutput("reset_out_ovf", longint'(out_ovf16), 0);
        checkOutput("reset_out_valid8", longint'(out_valid8), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", longint'(in_ready16), 1);
        @(posedge clk); #1;

        // Single all-ones beat and its two-edge latency.
        applyStimulus(ALL1, '0, 1'b0, 1'b1, 1'b0, 64);
        checkOutput("latency_e0", longint'(out_valid16), 0);
        @(posedge clk); #1;
        checkOutput("latency_e1", longint'(out_valid16), 0);
        @(posedge clk); #1;
        checkOutput("latency_e2", longint'(out_valid16), 1);
        waitDrain();

        applyStimulus(64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567, 1'b1, 1'b1, 1'b0, 64);
        applyStimulus(64'hDEADBEEF_01234567, ~64'hDEADBEEF_01234567, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(64'h0, 64'h00000000_000000FF, 1'b1, 1'b1, 1'b0, 56);
        waitDrain();

        // 3-beat frame then a single-beat frame; out_valid must stay high across both.
        applyStimulus(64'h0F0F0F0F_0F0F0F0F, '0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(ALL1, '0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(64'h0, '0, 1'b0, 1'b1, 1'b0, 96);
        applyStimulus(64'h1, '0, 1'b0, 1'b1, 1'b0, 1);
        @(posedge clk); #1;
        checkOutput("b2b_valid_first", longint'(out_valid16), 1);
        @(posedge clk); #1;
        checkOutput("b2b_valid_second", longint'(out_valid16), 1);
        waitDrain();

        out_ready = 1'b0;
        applyStimulus(64'hFF, '0, 1'b0, 1'b1, 1'b0, 8);
        applyStimulus(64'hFFFF, '0, 1'b0, 1'b1, 1'b0, 16);
        applyStimulus(64'h7, '0, 1'b0, 1'b1, 1'b0, 3);
        fork
            applyStimulus(64'h1F, '0, 1'b0, 1'b1, 1'b0, 5);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", longint'(in_ready16), 0);
                    checkOutput("stall_in_ready8", longint'(in_ready8), 0);
                    checkOutput("stall_out_data", longint'(out_data16), 8);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        // 320 ones saturates the 8-bit instance; the next frame must start clean.
        for (int k = 0; k < 4; k++) applyStimulus(ALL1, '0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(ALL1, '0, 1'b0, 1'b1, 1'b0, 320);
        applyStimulus(64'hFF, '0, 1'b0, 1'b1, 1'b0, 8);
        waitDrain();

        applyStimulus(ALL1, '0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(ALL1, '0, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset_out_valid", longint'(out_valid16), 0);
        checkOutput("midreset_out_data", longint'(out_data16), 0);
        checkOutput("midreset_out_data8", longint'(out_data8), 0);
        checkOutput("midreset_out_ovf8", longint'(out_ovf8), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(ALL1, '0, 1'b0, 1'b1, 1'b0, 64);
        waitDrain();

        applyStimulus(64'hFF, '0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(64'hFF, '0, 1'b0, 1'b1, 1'b1, 16);
        applyStimulus(ALL1, '0, 1'b0, 1'b1, 1'b0, 64);
        waitDrain();

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
